pellet_collector: RTL and testbench

Game-logic stage directly upstream of the dot map. Watches Pac-Man's current tile and queries the dot map's game-logic port. On a dot it issues a one-cycle clear, awards points and counts the dot. It also sequences the multi-cycle level restore (`level_reset` hold) at game start and after each cleared level, and reports score, level number and power-pellet events to the rest of the game.

---
 rtl/pellet_collector.sv | 156 +++++++++++++++
 tb/tb_pellet_collector.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_collector.sv
// pellet_collector: watches Pac-Man's tile, queries the dot map, clears eaten
// dots, keeps score / dot / level counters and sequences the level restore.
module pellet_collector #(
  parameter int unsigned DOT_POINTS     = 10,
  parameter int unsigned POWER_POINTS   = 50,
  parameter int unsigned SCORE_W        = 20,
  parameter int unsigned RESTORE_CYCLES = 1024   // must be >= 1008
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic [4:0]         pac_tile_x,
  input  logic [5:0]         pac_tile_y,
  input  logic               pac_tile_valid,
  input  logic               is_power_tile,
  input  logic               has_dot,
  input  logic [7:0]         dots_remaining,
  output logic [4:0]         tile_x,
  output logic [5:0]         tile_y,
  output logic               clear_dot,
  output logic               level_reset,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         dots_eaten,
  output logic [7:0]         level_num,
  output logic               eat_pulse,
  output logic               power_pellet,
  output logic               level_clear
);

  typedef enum logic [2:0] {
    IDLE, RESTORE, PLAY, CHECK, CLEAR, SETTLE, LVL_DONE
  } state_t;

  localparam int unsigned CNT_W = $clog2(RESTORE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RESTORE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W:0]   DOT_ADD   = (SCORE_W + 1)'(DOT_POINTS);
  localparam logic [SCORE_W:0]   POWER_ADD = (SCORE_W + 1)'(POWER_POINTS);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_restore_cnt;
  logic               r_force_check;
  logic [4:0]         r_tile_x;
  logic [5:0]         r_tile_y;
  logic               r_clear_dot;
  logic               r_level_reset;
  logic [SCORE_W-1:0] r_score;
  logic [7:0]         r_dots_eaten;
  logic [7:0]         r_level_num;
  logic               r_eat_pulse;
  logic               r_power_pellet;
  logic               r_level_clear;

  logic               w_tile_ok;
  logic               w_new_tile;
  logic [SCORE_W:0]   w_score_sum;

  // A tile is worth checking only when valid, on the maze, and either new
  // relative to the last processed tile or forced after a restore.
  assign w_tile_ok   = pac_tile_valid && (pac_tile_x <= 5'd27) && (pac_tile_y <= 6'd35);
  assign w_new_tile  = r_force_check || (pac_tile_x != r_tile_x) || (pac_tile_y != r_tile_y);
  // In CLEAR the power flag register still holds the eaten tile's type.
  assign w_score_sum = {1'b0, r_score} + (r_power_pellet ? POWER_ADD : DOT_ADD);

  // Next-state decode; game_start overrides every other transition.
  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = IDLE;
      RESTORE:  if (r_restore_cnt == CNT_LAST) w_next = PLAY;
      PLAY:     if (w_tile_ok && w_new_tile) w_next = CHECK;
      CHECK:    w_next = has_dot ? CLEAR : PLAY;
      CLEAR:    w_next = SETTLE;
      SETTLE:   w_next = (dots_remaining == 8'd0) ? LVL_DONE : PLAY;
      LVL_DONE: w_next = RESTORE;
      default:  w_next = IDLE;
    endcase
    if (game_start) w_next = RESTORE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Registered outputs and counters, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_restore_cnt  <= '0;
      r_force_check  <= 1'b1;
      r_tile_x       <= '0;
      r_tile_y       <= '0;
      r_clear_dot    <= 1'b0;
      r_level_reset  <= 1'b0;
      r_score        <= '0;
      r_dots_eaten   <= '0;
      r_level_num    <= '0;
      r_eat_pulse    <= 1'b0;
      r_power_pellet <= 1'b0;
      r_level_clear  <= 1'b0;
    end else begin
      r_clear_dot    <= (w_next == CLEAR);
      r_eat_pulse    <= (w_next == CLEAR);
      r_power_pellet <= (w_next == CLEAR) && is_power_tile;
      r_level_reset  <= (w_next == RESTORE);
      r_level_clear  <= (w_next == LVL_DONE);

      // Restart the hold count on every entry into RESTORE, including re-entry
      // caused by game_start while already restoring.
      if (w_next == RESTORE) begin
        r_restore_cnt <= (r_state == RESTORE && !game_start) ? r_restore_cnt + 1'b1 : '0;
      end

      if (w_next == CHECK) begin
        r_tile_x      <= pac_tile_x;
        r_tile_y      <= pac_tile_y;
        r_force_check <= 1'b0;
      end

      if (r_state == CLEAR) begin
        if (r_dots_eaten != 8'hFF) r_dots_eaten <= r_dots_eaten + 8'd1;
        r_score <= w_score_sum[SCORE_W] ? SCORE_MAX : w_score_sum[SCORE_W-1:0];
      end

      if (r_state == LVL_DONE && r_level_num != 8'hFF) begin
        r_level_num <= r_level_num + 8'd1;
      end

      // Later assignments take priority over the updates above.
      if (w_next == RESTORE) begin
        r_dots_eaten  <= '0;
        r_force_check <= 1'b1;
      end
      if (game_start) begin
        r_score     <= '0;
        r_level_num <= '0;
      end
    end
  end

  assign tile_x       = r_tile_x;
  assign tile_y       = r_tile_y;
  assign clear_dot    = r_clear_dot;
  assign level_reset  = r_level_reset;
  assign score        = r_score;
  assign dots_eaten   = r_dots_eaten;
  assign level_num    = r_level_num;
  assign eat_pulse    = r_eat_pulse;
  assign power_pellet = r_power_pellet;
  assign level_clear  = r_level_clear;

endmodule

// File: tb/tb_pellet_collector.sv
// Bench for pellet_collector: emulates the dot map and level ROM, drives a
// vector table, multi-cycle corner sequences and a randomized phase checked
// against a tile-level scoring model.
module tb_pellet_collector;

  localparam int RESTORE_LEN = 1024;
  localparam int LAYOUT_DOTS = 35;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        game_start = 1'b0;
  logic [4:0]  pac_tile_x = '0;
  logic [5:0]  pac_tile_y = '0;
  logic        pac_tile_valid = 1'b0;
  logic        is_power_tile;
  logic        has_dot;
  logic [7:0]  dots_remaining;
  logic [4:0]  tile_x;
  logic [5:0]  tile_y;
  logic        clear_dot;
  logic        level_reset;
  logic [19:0] score;
  logic [7:0]  dots_eaten;
  logic [7:0]  level_num;
  logic        eat_pulse;
  logic        power_pellet;
  logic        level_clear;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pellet_collector dut (
    .clk(clk), .rst_n(rst_n), .game_start(game_start),
    .pac_tile_x(pac_tile_x), .pac_tile_y(pac_tile_y), .pac_tile_valid(pac_tile_valid),
    .is_power_tile(is_power_tile), .has_dot(has_dot), .dots_remaining(dots_remaining),
    .tile_x(tile_x), .tile_y(tile_y), .clear_dot(clear_dot), .level_reset(level_reset),
    .score(score), .dots_eaten(dots_eaten), .level_num(level_num),
    .eat_pulse(eat_pulse), .power_pellet(power_pellet), .level_clear(level_clear)
  );

  // Level layout: dots on odd columns 1..13 of rows 4..8 (35 dots).
  function automatic bit layout(input int x, input int y);
    return (y >= 4 && y <= 8 && x >= 1 && x <= 13 && (x % 2) == 1);
  endfunction

  function automatic bit is_pwr(input int x, input int y);
    return (x == 1 && y == 6) || (x == 13 && y == 8);
  endfunction

  // Dot map emulator: restore on level_reset, clear on clear_dot, or load a
  // single-dot map on request from the stimulus.
  bit   dmap [36][28];
  int   dcnt;
  logic load_single = 1'b0;
  int   load_x = 0;
  int   load_y = 0;

  always @(posedge clk) begin
    if (level_reset) begin
      for (int y = 0; y < 36; y++)
        for (int x = 0; x < 28; x++) dmap[y][x] <= layout(x, y);
      dcnt <= LAYOUT_DOTS;
    end else if (load_single) begin
      for (int y = 0; y < 36; y++)
        for (int x = 0; x < 28; x++) dmap[y][x] <= (x == load_x && y == load_y);
      dcnt <= 1;
    end else if (clear_dot && tile_x <= 5'd27 && tile_y <= 6'd35 &&
                 dmap[int'(tile_y)][int'(tile_x)]) begin
      dmap[int'(tile_y)][int'(tile_x)] <= 1'b0;
      dcnt <= dcnt - 1;
    end
  end

  assign dots_remaining = 8'(dcnt);
  assign has_dot = (tile_x <= 5'd27 && tile_y <= 6'd35) ? dmap[int'(tile_y)][int'(tile_x)] : 1'b0;
  assign is_power_tile = is_pwr(int'(tile_x), int'(tile_y));

  // Invariant monitors.
  bit overlap_seen;
  bit stray_pwr;
  always @(posedge clk) begin
    if (clear_dot && level_reset) overlap_seen <= 1'b1;
    if (power_pellet && !clear_dot) stray_pwr <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic count_restore(input string name);
    int n = 0;
    while (level_reset === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, RESTORE_LEN);
  endtask

  task automatic start_game();
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    check("lr_rises", level_reset, 1);
    count_restore("restore_len");
    check("start_score", score, 0);
    check("start_level", level_num, 0);
    check("start_dots", dots_eaten, 0);
  endtask

  typedef struct {
    logic [4:0] x;
    logic [5:0] y;
    logic       v;
    int         hold;
    int         clears;
    int         lat;
    int         pwr;
    int         sc;
    int         dots;
  } vec_t;

  vec_t vecs [10];

  task automatic apply_vec(input vec_t v, input int idx);
    int clears = 0, eats = 0, pwr = 0, lat = -1;
    logic [4:0] cx = '0;
    logic [5:0] cy = '0;
    pac_tile_x = v.x;
    pac_tile_y = v.y;
    pac_tile_valid = v.v;
    for (int i = 1; i <= v.hold; i++) begin
      @(negedge clk);
      if (clear_dot) begin
        clears++;
        if (lat < 0) lat = i;
        cx = tile_x;
        cy = tile_y;
      end
      if (eat_pulse) eats++;
      if (power_pellet && clear_dot) pwr++;
    end
    check($sformatf("v%0d_clears", idx), clears, v.clears);
    check($sformatf("v%0d_eats", idx), eats, v.clears);
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_power", idx), pwr, v.pwr);
    check($sformatf("v%0d_score", idx), score, v.sc);
    check($sformatf("v%0d_dots", idx), dots_eaten, v.dots);
    if (clears > 0) begin
      check($sformatf("v%0d_tile_x", idx), cx, v.x);
      check($sformatf("v%0d_tile_y", idx), cy, v.y);
    end
  endtask

  // Tile-level scoring model for the randomized phase.
  bit em [36][28];
  int exp_score;
  int exp_dots;
  int exp_left;

  initial begin
    vecs[0] = '{5'd1,  6'd4,  1'b1, 6,   1,  2, 0, 10,  1};
    vecs[1] = '{5'd1,  6'd4,  1'b1, 100, 0, -1, 0, 10,  1};
    vecs[2] = '{5'd2,  6'd4,  1'b1, 6,   0, -1, 0, 10,  1};
    vecs[3] = '{5'd1,  6'd6,  1'b1, 6,   1,  2, 1, 60,  2};
    vecs[4] = '{5'd3,  6'd5,  1'b0, 6,   0, -1, 0, 60,  2};
    vecs[5] = '{5'd30, 6'd5,  1'b1, 6,   0, -1, 0, 60,  2};
    vecs[6] = '{5'd3,  6'd40, 1'b1, 6,   0, -1, 0, 60,  2};
    vecs[7] = '{5'd3,  6'd5,  1'b1, 6,   1,  2, 0, 70,  3};
    vecs[8] = '{5'd1,  6'd4,  1'b1, 6,   0, -1, 0, 70,  3};
    vecs[9] = '{5'd13, 6'd8,  1'b1, 6,   1,  2, 1, 120, 4};

    // Reset values.
    #3;
    check("rst_tile_x", tile_x, 0);
    check("rst_tile_y", tile_y, 0);
    check("rst_clear", clear_dot, 0);
    check("rst_lreset", level_reset, 0);
    check("rst_score", score, 0);
    check("rst_dots", dots_eaten, 0);
    check("rst_level", level_num, 0);
    check("rst_pulses", {eat_pulse, power_pellet, level_clear}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_restore", level_reset, 0);

    start_game();

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Last dot eaten: level clear, next level, fresh restore, score kept.
    pac_tile_valid = 1'b0;
    load_x = 5;
    load_y = 5;
    load_single = 1'b1;
    @(negedge clk);
    load_single = 1'b0;
    pac_tile_x = 5'd5;
    pac_tile_y = 6'd5;
    pac_tile_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("last_clear", clear_dot, 1);
    @(negedge clk);
    check("last_score", score, 130);
    check("last_dots", dots_eaten, 5);
    check("settle_no_lclear", level_clear, 0);
    @(negedge clk);
    check("lclear_pulse", level_clear, 1);
    check("lclear_no_lreset", level_reset, 0);
    pac_tile_valid = 1'b0;
    @(negedge clk);
    check("lclear_once", level_clear, 0);
    check("level_num", level_num, 1);
    check("dots_zeroed", dots_eaten, 0);
    check("score_kept", score, 130);
    count_restore("restore2_len");
    check("level_after", level_num, 1);
    check("score_after", score, 130);

    // Async reset while clear_dot is high.
    pac_tile_x = 5'd7;
    pac_tile_y = 6'd7;
    pac_tile_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_clear_high", clear_dot, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_clear", clear_dot, 0);
    check("arst_score", score, 0);
    check("arst_level", level_num, 0);
    check("arst_tile", {tile_x, tile_y}, 0);
    pac_tile_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_game();

    // game_start during CLEAR restarts the restore and drops the clear.
    pac_tile_x = 5'd7;
    pac_tile_y = 6'd7;
    pac_tile_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("gs_clear_high", clear_dot, 1);
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    pac_tile_valid = 1'b0;
    check("gs_clear_drop", clear_dot, 0);
    check("gs_score", score, 0);
    check("gs_dots", dots_eaten, 0);
    count_restore("gs_restore_len");

    // Randomized phase against the tile-level model.
    for (int y = 0; y < 36; y++)
      for (int x = 0; x < 28; x++) em[y][x] = layout(x, y);
    exp_score = 0;
    exp_dots = 0;
    exp_left = LAYOUT_DOTS;
    for (int it = 0; it < 50; it++) begin
      int x, y, clears;
      bit v, eat;
      if ($urandom_range(0, 9) < 7) begin
        x = $urandom_range(0, 14);
        y = $urandom_range(3, 9);
      end else begin
        x = $urandom_range(0, 31);
        y = $urandom_range(0, 40);
      end
      v = ($urandom_range(0, 7) != 0);
      eat = v && x <= 27 && y <= 35 && em[y][x];
      if (eat && exp_left == 1) begin
        v = 1'b0;
        eat = 1'b0;
      end
      if (eat) begin
        em[y][x] = 1'b0;
        exp_left--;
        exp_dots++;
        exp_score += is_pwr(x, y) ? 50 : 10;
      end
      pac_tile_x = 5'(x);
      pac_tile_y = 6'(y);
      pac_tile_valid = v;
      clears = 0;
      repeat (6) begin
        @(negedge clk);
        if (clear_dot) clears++;
      end
      check($sformatf("rnd%0d_clears", it), clears, eat ? 1 : 0);
      check($sformatf("rnd%0d_score", it), score, exp_score);
      check($sformatf("rnd%0d_dots", it), dots_eaten, exp_dots);
    end
    pac_tile_valid = 1'b0;

    // Async reset in the middle of a restore, then stay idle.
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_restore_high", level_reset, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lreset", level_reset, 0);
    check("arst_dots", dots_eaten, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_after_rst", {level_reset, clear_dot}, 0);

    check("no_clear_in_restore", overlap_seen, 0);
    check("power_only_with_clear", stray_pwr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
